// File: rtl/demux1t2_8_buf.sv
// Buffered 1-to-2 byte demultiplexer.
// Each upstream byte is steered by in_sel into one of two small FIFOs.
// Each FIFO drains to its own valid/ready consumer.
// Per-channel push counters (mod 256) are kept for debug display.
module demux1t2_8_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] o0_data,
  output logic             o0_valid,
  input  logic             o0_ready,
  output logic [WIDTH-1:0] o1_data,
  output logic             o1_valid,
  input  logic             o1_ready,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
);

  // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r     [2][DEPTH];
  logic [AW-1:0]    wr_ptr_r  [2];
  logic [AW-1:0]    rd_ptr_r  [2];
  logic [CW-1:0]    count_r   [2];
  logic [7:0]       push_cnt_r[2];

  logic [1:0] full_s;
  logic [1:0] push_s;
  logic [1:0] pop_s;
  logic [1:0] out_ready_s;
  logic       in_ready_s;

  assign out_ready_s = {o1_ready, o0_ready};

  // Full flags, upstream ready, and per-channel push/pop strobes.
  // in_ready depends only on registered occupancy and in_sel, never on the consumer readies.
  always_comb begin
    full_s     = 2'b00;
    push_s     = 2'b00;
    pop_s      = 2'b00;
    in_ready_s = 1'b1;
    for (int k = 0; k < 2; k++) begin
      full_s[k] = (count_r[k] == FULL_CNT);
      pop_s[k]  = (count_r[k] != {CW{1'b0}}) && out_ready_s[k];
    end
    in_ready_s = in_sel ? !full_s[1] : !full_s[0];
    push_s[0]  = in_valid && in_ready_s && !in_sel;
    push_s[1]  = in_valid && in_ready_s &&  in_sel;
  end

  // FIFO storage, pointers, occupancy and push counters for both channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int d = 0; d < DEPTH; d++) begin
          mem_r[k][d] <= {WIDTH{1'b0}};
        end
        wr_ptr_r[k]   <= {AW{1'b0}};
        rd_ptr_r[k]   <= {AW{1'b0}};
        count_r[k]    <= {CW{1'b0}};
        push_cnt_r[k] <= 8'd0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push_s[k]) begin
          mem_r[k][wr_ptr_r[k]] <= in_data;
          wr_ptr_r[k]           <= wr_ptr_r[k] + {{(AW-1){1'b0}}, 1'b1};
          push_cnt_r[k]         <= push_cnt_r[k] + 8'd1;
        end else begin
          wr_ptr_r[k]           <= wr_ptr_r[k];
          push_cnt_r[k]         <= push_cnt_r[k];
        end
        if (pop_s[k]) begin
          rd_ptr_r[k] <= rd_ptr_r[k] + {{(AW-1){1'b0}}, 1'b1};
        end else begin
          rd_ptr_r[k] <= rd_ptr_r[k];
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push_s[k], pop_s[k]})
          2'b10:   count_r[k] <= count_r[k] + {{(CW-1){1'b0}}, 1'b1};
          2'b01:   count_r[k] <= count_r[k] - {{(CW-1){1'b0}}, 1'b1};
          default: count_r[k] <= count_r[k];
        endcase
      end
    end
  end

  assign in_ready = in_ready_s;
  assign o0_data  = mem_r[0][rd_ptr_r[0]];
  assign o1_data  = mem_r[1][rd_ptr_r[1]];
  assign o0_valid = (count_r[0] != {CW{1'b0}});
  assign o1_valid = (count_r[1] != {CW{1'b0}});
  assign cnt0     = push_cnt_r[0];
  assign cnt1     = push_cnt_r[1];

endmodule

// File: doc/demux1t2_8_buf.md
# demux1t2_8_buf

Buffered 1-to-2 byte demultiplexer, the steering counterpart of the 2:1 byte select mux in the display/game datapath. A single upstream byte stream carries a per-byte select bit. Each byte is routed into one of two per-channel FIFOs, and each FIFO drains to its own downstream consumer through a valid/ready handshake. Per-channel accepted-byte counters are provided for debug display.

## Interface
- WIDTH, 8, data width of every byte path
- DEPTH, 2, entries per channel FIFO; power of two, at least 2
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  upstream byte
- in_sel  input  1  destination: 0 = channel 0, 1 = channel 1
- in_valid  input  1  upstream byte and sel are valid
- in_ready  output  1  block accepts this cycle
- o0_data  output  WIDTH  channel 0 head byte
- o0_valid  output  1  channel 0 FIFO non-empty
- o0_ready  input  1  channel 0 consumer takes head
- o1_data  output  WIDTH  channel 1 head byte
- o1_valid  output  1  channel 1 FIFO non-empty
- o1_ready  input  1  channel 1 consumer takes head
- cnt0  output  8  bytes accepted into channel 0, mod 256
- cnt1  output  8  bytes accepted into channel 1, mod 256

## Operation
- Push rule:
  - in_ready = !full[in_sel], combinational from registered FIFO state and in_sel.
  - Push into channel in_sel when in_valid && in_ready.
- Holding data: while in_valid is high and in_ready is low, upstream must hold in_data and in_sel stable.
- Pop rule: channel k pops when ok_valid && ok_ready.
- Per-channel FIFO:
  - Write pointer, read pointer, and occupancy count (0..DEPTH).
  - Pointers wrap modulo DEPTH.
  - full = (count == DEPTH); ok_valid = (count != 0).
  - ok_data = mem[rd_ptr], driven from registered storage with no input bypass.
- Simultaneous push and pop on the same channel:
  - count unchanged, both pointers advance.
  - This is legal when count is from 1 to DEPTH-1.
  - When count == DEPTH, no push occurs because in_ready is low. The pop alone proceeds.
  - When count == 0, no pop occurs. The push alone proceeds.
- Channel independence: a full channel blocks only bytes selected to it. A byte for the other channel is accepted in the same cycle. There is no head-of-line blocking beyond the current upstream byte.
- Counters: cntk increments by 1 on each push to channel k and wraps 255 -> 0. Pops do not affect the counter.
- Ignored inputs: o0_ready and o1_ready are ignored while the corresponding valid is low.
- Reset (rst_n low, asynchronous):
  - All pointers, counts, cnt0 and cnt1 cleared to 0.
  - o0_valid = o1_valid = 0; o0_data = o1_data = 0 (storage cleared).
  - in_ready = 1.
  - Reset mid-transfer discards buffered bytes with no partial output.

## Timing
- Latency: a byte pushed at edge N is visible on ok_data with ok_valid = 1 after edge N, i.e. in the cycle following acceptance.
- Throughput: one push per cycle total, and one pop per cycle per channel concurrently.
- in_ready changes with in_sel within the cycle. It has no path from o0_ready or o1_ready, so a freed slot is visible one cycle after the pop.
- Head order: ok_data/ok_valid change only at clock edges, or asynchronously on reset assertion. Head order is strict FIFO per channel.
- Deassertion of rst_n takes effect at the next rising edge. The first push is possible in the cycle after deassertion.

## Test plan
- Reset: hold rst_n = 0 mid-stream with channel 0 holding 2 bytes -> o0_valid = 0, o1_valid = 0, cnt0 = cnt1 = 0, in_ready = 1 immediately. No stale byte appears after release.
- Routing/latency: push 0xA5 with sel = 0, then 0x3C with sel = 1, with both readies low -> o0_data = 0xA5 one cycle after the first push and o1_data = 0x3C one cycle after the second push, both valid. cnt0 = 1, cnt1 = 1.
- Full/backpressure: with o0_ready = 0, push 0x01, 0x02, 0x03 to channel 0 -> in_ready drops after 2 accepts. The third byte is held until o0_ready = 1 for one cycle, then accepted the following cycle. Drain order is 0x01, 0x02, 0x03.
- Independence: channel 0 full, present sel = 1 with 0x77 -> accepted immediately. o1_valid = 1 next cycle; channel 0 contents are unchanged.
- Simultaneous push/pop: channel 1 count = 1 holding 0x10, o1_ready = 1 while pushing 0x20 to channel 1 -> count stays 1 and o1_data = 0x20 next cycle. Then stream 0x00..0xFF continuously with o1_ready = 1 -> in order, no drops.
- Counter wrap: accept 256 bytes into channel 0 -> cnt0 returns to 0 and cnt1 is unchanged.
